// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and helpers for the MMU sequencer (mmu_ctrl).
package tpu_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, COMPUTE, DRAIN} mmu_ctrl_state_t;

    function automatic int DRAIN_CYCLES(input int size, input int pipe_lat);
        return 2 * size - 2 + pipe_lat;
    endfunction

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/mmu_ctrl_if.sv
// mmu_ctrl_if: job, tile-stream, MMU-pin and result signals of one mmu_ctrl instance.
interface mmu_ctrl_if #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic                     start;
    logic                     busy;
    logic                     wt_valid;
    logic                     wt_ready;
    logic [SIZE*DATA_W-1:0]   wt_row;
    logic                     in_valid;
    logic                     in_ready;
    logic [SIZE*DATA_W-1:0]   in_row;
    logic                     mmu_control;
    logic                     mmu_reset;
    logic [SIZE*DATA_W-1:0]   mmu_data;
    logic [SIZE*DATA_W-1:0]   mmu_wt;
    logic [SIZE*ACC_W-1:0]    mmu_acc;
    logic                     res_valid;
    logic [SIZE*ACC_W-1:0]    res_row;
    logic                     done;
    logic                     err_underrun;

    modport master (
        output start, wt_valid, wt_row, in_valid, in_row, mmu_acc,
        input  busy, wt_ready, in_ready, mmu_control, mmu_reset, mmu_data, mmu_wt,
               res_valid, res_row, done, err_underrun
    );

    modport slave (
        input  start, wt_valid, wt_row, in_valid, in_row, mmu_acc,
        output busy, wt_ready, in_ready, mmu_control, mmu_reset, mmu_data, mmu_wt,
               res_valid, res_row, done, err_underrun
    );
endinterface

// File: rtl/mmu_ctrl_skew_buf.sv
// skew_buf: per-lane delay line; lane i delayed i cycles, or LANES-1-i when REVERSE.
module skew_buf
    import tpu_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int W       = 8,
    parameter bit REVERSE = 1'b0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [LANES*W-1:0] din,
    output logic [LANES*W-1:0] dout
);
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int D = REVERSE ? LANES - 1 - i : i;
        if (D == 0) begin : g_wire
            assign dout[lane_lsb(i, W) +: W] = din[lane_lsb(i, W) +: W];
        end else begin : g_dly
            logic [D*W-1:0] sr;
            if (D == 1) begin : g_one
                always_ff @(posedge clk)
                    sr <= clr ? '0 : din[lane_lsb(i, W) +: W];
            end else begin : g_many
                always_ff @(posedge clk)
                    sr <= clr ? '0 : {sr[(D-1)*W-1:0], din[lane_lsb(i, W) +: W]};
            end
            assign dout[lane_lsb(i, W) +: W] = sr[D*W-1 -: W];
        end
    end
endmodule

// File: rtl/mmu_ctrl.sv
// mmu_ctrl: job sequencer for a SIZE x SIZE weight-stationary MMU (skew, weight load, de-skew).
// Optional MMU_CTRL_PERF_EN adds stall and job counters.
module mmu_ctrl
    import tpu_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    mmu_ctrl_if.slave   bus
`ifdef MMU_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_jobs
`endif
);
    localparam int DRAIN_N = DRAIN_CYCLES(SIZE, PIPE_LAT);
    localparam int CW      = $clog2(DRAIN_N);
    localparam logic [CW-1:0] SZ_LAST   = CW'(SIZE - 1);
    localparam logic [CW-1:0] DR_LAST   = CW'(DRAIN_N - 1);
    localparam logic [CW-1:0] RES_FIRST = CW'(DRAIN_N - SIZE);

    mmu_ctrl_state_t        state;
    logic [CW-1:0]          cnt;
    logic                   done_r;
    logic                   err_r;
    logic                   load;
    logic                   clr;
    logic [SIZE*DATA_W-1:0] inj;
    logic [SIZE*ACC_W-1:0]  deskew;

    assign load             = state == LOAD_W && bus.wt_valid;
    assign clr              = reset || state == CLEAR;
    assign bus.busy         = state != IDLE;
    assign bus.wt_ready     = load;
    assign bus.mmu_control  = load;
    assign bus.mmu_wt       = load ? bus.wt_row : '0;
    assign bus.in_ready     = state == COMPUTE;
    assign bus.mmu_reset    = clr;
    assign bus.res_valid    = state == DRAIN && cnt >= RES_FIRST;
    assign bus.res_row      = bus.res_valid ? deskew : '0;
    assign bus.done         = done_r;
    assign bus.err_underrun = err_r;
    // a missing data row is replaced by zeros so the array still sees SIZE rows
    assign inj              = bus.in_ready && bus.in_valid ? bus.in_row : '0;

    always_ff @(posedge clk)
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state <= CLEAR;
                    err_r <= 1'b0;
                end
                CLEAR: begin
                    state <= LOAD_W;
                    cnt   <= '0;
                end
                LOAD_W: if (bus.wt_valid) begin
                    cnt   <= cnt == SZ_LAST ? '0 : cnt + 1'b1;
                    state <= cnt == SZ_LAST ? COMPUTE : LOAD_W;
                end
                COMPUTE: begin
                    err_r <= err_r || !bus.in_valid;
                    cnt   <= cnt == SZ_LAST ? '0 : cnt + 1'b1;
                    state <= cnt == SZ_LAST ? DRAIN : COMPUTE;
                end
                DRAIN: if (cnt == DR_LAST) begin
                    state  <= IDLE;
                    done_r <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end

    skew_buf #(.LANES(SIZE), .W(DATA_W), .REVERSE(1'b0)) u_skew (
        .clk  (clk),
        .clr  (clr),
        .din  (inj),
        .dout (bus.mmu_data)
    );

    // later columns leave the array later, so they get the shorter delay
    skew_buf #(.LANES(SIZE), .W(ACC_W), .REVERSE(1'b1)) u_deskew (
        .clk  (clk),
        .clr  (clr),
        .din  (bus.mmu_acc),
        .dout (deskew)
    );

`ifdef MMU_CTRL_PERF_EN
    always_ff @(posedge clk)
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_jobs         <= '0;
        end else begin
            if (state == LOAD_W && !bus.wt_valid && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            perf_jobs <= perf_jobs + 16'(done_r);
        end
`endif
endmodule

// File: tb/tb_mmu_ctrl.sv
// tb_mmu_ctrl: randomized jobs against a matrix-product reference and a behavioural MMU model.
module tb_mmu_ctrl;
    localparam int SIZE = 4, PIPE_LAT = 2;
    localparam int LAT  = 2 * SIZE - 2 + PIPE_LAT;

    typedef struct { int c; logic [127:0] row; } res_t;

    logic clk = 1'b0, reset = 1'b1;
    int   cyc = 0, tests = 0, fails = 0, t0 = 0, gap = 0;
    bit   hold = 1'b0;
    logic [3:0]  vmask;
    logic [7:0]  wm [4][4];
    logic [7:0]  dm [4][4];
    logic [31:0] hist [16];
    logic [31:0] wq [4];
    res_t exp_q [$];
    int   done_q [$];

    mmu_ctrl_if bus ();
`ifdef MMU_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_jobs;
`endif

    mmu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MMU_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_jobs         (perf_jobs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pack_w(input int r);
        return {wm[r][3], wm[r][2], wm[r][1], wm[r][0]};
    endfunction

    function automatic logic [31:0] pack_d(input int k);
        return {dm[k][3], dm[k][2], dm[k][1], dm[k][0]};
    endfunction

    // MMU stand-in: weight shift register plus data history; column j of the
    // accumulator sees lane i after PIPE_LAT + (SIZE-1-i) + j cycles
    always @(negedge clk) begin
        if (bus.mmu_reset)
            for (int i = 0; i < 16; i++) hist[i] = '0;
        hist[cyc % 16] = bus.mmu_data;
        if (bus.mmu_control) begin
            for (int i = 0; i < 3; i++) wq[i] = wq[i+1];
            wq[3] = bus.mmu_wt;
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int j = 0; j < SIZE; j++) begin
            logic [31:0] acc;
            acc = '0;
            for (int i = 0; i < SIZE; i++) begin
                int idx;
                idx = cyc - PIPE_LAT - (SIZE - 1 - i) - j;
                if (idx >= 0) acc += 32'(wq[i][j*8 +: 8]) * 32'(hist[idx % 16][i*8 +: 8]);
            end
            bus.mmu_acc[j*32 +: 32] = acc;
        end
    end

    always @(negedge clk) begin : mon
        res_t e;
        int   d;
        if (bus.res_valid) begin
            if (exp_q.size() == 0) check("res_unexpected", bus.res_valid, 0);
            else begin
                e = exp_q.pop_front();
                check("res_cycle", cyc, e.c);
                check("res_row", bus.res_row, e.row);
            end
        end
        if (bus.done) begin
            if (done_q.size() == 0) check("done_unexpected", bus.done, 0);
            else begin
                d = done_q.pop_front();
                check("done_cycle", cyc, d);
            end
        end
    end

    task automatic run_job();
        int n;
        logic [127:0] row;
        logic [31:0]  s;
        bus.start = 1'b1;
        step();
        bus.start = hold;
        check("err_clear_on_start", bus.err_underrun, 0);
        for (int r = 0; r < SIZE; r++) begin
            if (r > 0 && gap > 0) begin
                bus.wt_valid = 1'b0;
                repeat (gap) step();
            end
            bus.wt_valid = 1'b1;
            bus.wt_row   = pack_w(r);
            n = 0;
            @(negedge clk);
            while (!bus.wt_ready && n < 100) begin n++; @(negedge clk); end
            if (!bus.wt_ready) begin
                check("wt_timeout", bus.wt_ready, 1);
                bus.wt_valid = 1'b0;
                return;
            end
            step();
        end
        bus.wt_valid = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            bus.in_valid = vmask[k];
            bus.in_row   = vmask[k] ? pack_d(k) : $urandom();
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 100) begin n++; @(negedge clk); end
            if (!bus.in_ready) begin
                check("in_timeout", bus.in_ready, 1);
                bus.in_valid = 1'b0;
                return;
            end
            if (k == 0) t0 = cyc;
            step();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            row = '0;
            for (int j = 0; j < SIZE; j++) begin
                s = '0;
                for (int i = 0; i < SIZE; i++)
                    if (vmask[k]) s += 32'(dm[k][i]) * 32'(wm[i][j]);
                row[j*32 +: 32] = s;
            end
            exp_q.push_back('{c: t0 + LAT + k, row: row});
        end
        done_q.push_back(t0 + LAT + SIZE);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || done_q.size() != 0 || bus.busy) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) check("idle_timeout", 128'(exp_q.size() + done_q.size()) + 128'(bus.busy), 0);
        step();
    endtask

    task automatic rand_tile();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wm[i][j] = 8'($urandom);
                dm[i][j] = 8'($urandom);
            end
    endtask

    task automatic ident_tile();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wm[i][j] = (i == j) ? 8'd1 : 8'd0;
                dm[i][j] = 8'(4 * i + j + 1);
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) hist[i] = '0;
        for (int i = 0; i < 4; i++) wq[i] = '0;
        bus.start = 0; bus.wt_valid = 0; bus.wt_row = '0;
        bus.in_valid = 0; bus.in_row = '0; bus.mmu_acc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_wt_ready", bus.wt_ready, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mmu_control", bus.mmu_control, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err_underrun, 0);
        check("rst_mmu_data", bus.mmu_data, 0);
        check("rst_mmu_wt", bus.mmu_wt, 0);
        check("rst_res_row", bus.res_row, 0);
        check("rst_mmu_reset", bus.mmu_reset, 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_mmu_reset", bus.mmu_reset, 0);
        step();

        ident_tile(); vmask = 4'hf; gap = 0; hold = 0;
        run_job(); wait_idle();

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin wm[i][j] = 8'd2; dm[i][j] = 8'd1; end
        run_job(); wait_idle();

        ident_tile(); gap = 3;
        run_job(); wait_idle();
        gap = 0;
`ifdef MMU_CTRL_PERF_EN
        check("perf_stall", perf_stall_cycles, 9);
        check("perf_jobs", perf_jobs, 3);
`endif

        rand_tile(); vmask = 4'b1011;
        run_job(); wait_idle();
        check("err_set", bus.err_underrun, 1);
        repeat (3) step();
        check("err_sticky", bus.err_underrun, 1);

        rand_tile(); vmask = 4'hf;
        run_job();
        n = 0;
        @(negedge clk);
        while (cyc < t0 + 5 && n < 50) begin n++; @(negedge clk); end
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("busy_after_reset", bus.busy, 0);
        check("err_after_reset", bus.err_underrun, 0);
        repeat (12) step();

        rand_tile();
        run_job(); wait_idle();

        rand_tile(); hold = 1;
        run_job();
        n = 0;
        @(negedge clk);
        while (!bus.done && n < 50) begin n++; @(negedge clk); end
        check("b2b_done_seen", bus.done, 1);
        @(negedge clk);
        check("b2b_clear", bus.mmu_reset, 1);
        rand_tile(); hold = 0;
        run_job(); wait_idle();

        for (int r = 0; r < 4; r++) begin
            rand_tile();
            gap   = $urandom_range(0, 2);
            vmask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
            run_job(); wait_idle();
        end

        check("pending", 128'(exp_q.size() + done_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
